// File: rtl/vga_fb_scanout_if.sv
// Framebuffer read port plus VGA pin bundle for the scanout block.
// master = scanout side, slave = RAM/DAC side.
interface vga_fb_scanout_if;
    logic [18:0] ram_rdaddr;
    logic [7:0]  ram_q;
    logic        hsync;
    logic        vsync;
    logic        blank_n;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        frame_start;

    modport master (
        output ram_rdaddr,
        input  ram_q,
        output hsync, vsync, blank_n,
        output vga_r, vga_g, vga_b,
        output frame_start
    );

    modport slave (
        input  ram_rdaddr,
        output ram_q,
        input  hsync, vsync, blank_n,
        input  vga_r, vga_g, vga_b,
        input  frame_start
    );
endinterface

// File: rtl/vga_fb_scanout.sv
// VGA timing generator that scans the upscaled grayscale framebuffer, centres the
// image with black borders and keeps syncs, blank_n and pixels aligned at 3 clocks.
module vga_fb_scanout #(
    parameter int unsigned LARGURA = 160,
    parameter int unsigned ALTURA  = 120,
    parameter int unsigned H_VIS   = 640,
    parameter int unsigned H_FP    = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned V_VIS   = 480,
    parameter int unsigned V_FP    = 10,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 33
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        fator,
    input  logic              fb_ready,
    vga_fb_scanout_if.master  bus
);

    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    typedef struct packed {
        logic show;
        logic vis;
        logic hs;
        logic vs;
        logic fs;
    } stage_t;

    localparam stage_t STAGE_RST = '{show: 1'b0, vis: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

    logic [9:0]  h_q, h_d, v_q, v_d;
    logic [2:0]  f_q, f_d;
    logic        rdy_q, rdy_d;
    logic [18:0] addr_q, addr_d;
    stage_t      st1_q, st1_d, st2_q, st2_d;
    logic [7:0]  pix_q, pix_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        blank_q, blank_d, fs_q, fs_d;

    int unsigned hh, vv, fi, img_w, img_h, off_x, off_y;
    logic        frame_top, in_img;

    always_comb begin
        hh        = 32'(h_q);
        vv        = 32'(v_q);
        frame_top = (h_q == '0) && (v_q == '0);

        // Latch is transparent at (0,0) so the frame's first pixel already sees the new settings.
        f_d   = f_q;
        rdy_d = rdy_q;
        if (frame_top) begin
            f_d   = (fator == 3'd0 || fator > 3'd4) ? 3'd1 : fator;
            rdy_d = fb_ready;
        end

        fi    = 32'(f_d);
        img_w = LARGURA * fi;
        img_h = ALTURA * fi;
        off_x = (H_VIS - img_w) / 2;
        off_y = (V_VIS - img_h) / 2;

        h_d = (hh == H_TOT - 1) ? '0 : h_q + 10'd1;
        v_d = v_q;
        if (hh == H_TOT - 1) begin
            v_d = (vv == V_TOT - 1) ? '0 : v_q + 10'd1;
        end

        st1_d     = STAGE_RST;
        st1_d.vis = (hh < H_VIS) && (vv < V_VIS);
        in_img    = st1_d.vis && (hh >= off_x) && (hh < off_x + img_w)
                    && (vv >= off_y) && (vv < off_y + img_h);
        st1_d.show = in_img && rdy_d;
        st1_d.hs   = !((hh >= H_VIS + H_FP) && (hh < H_VIS + H_FP + H_SYNC));
        st1_d.vs   = !((vv >= V_VIS + V_FP) && (vv < V_VIS + V_FP + V_SYNC));
        st1_d.fs   = frame_top;

        addr_d = in_img ? 19'((vv - off_y) * img_w + (hh - off_x)) : '0;

        st2_d   = st1_q;
        pix_d   = st2_q.show ? bus.ram_q : '0;
        hsync_d = st2_q.hs;
        vsync_d = st2_q.vs;
        blank_d = st2_q.vis;
        fs_d    = st2_q.fs;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_q     <= '0;
            v_q     <= '0;
            f_q     <= 3'd1;
            rdy_q   <= 1'b0;
            addr_q  <= '0;
            st1_q   <= STAGE_RST;
            st2_q   <= STAGE_RST;
            pix_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            blank_q <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            f_q     <= f_d;
            rdy_q   <= rdy_d;
            addr_q  <= addr_d;
            st1_q   <= st1_d;
            st2_q   <= st2_d;
            pix_q   <= pix_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            blank_q <= blank_d;
            fs_q    <= fs_d;
        end
    end

    assign bus.ram_rdaddr  = addr_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.blank_n     = blank_q;
    assign bus.vga_r       = pix_q;
    assign bus.vga_g       = pix_q;
    assign bus.vga_b       = pix_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout: a reduced-timing instance (64x48 visible, 16x12 source)
// for geometry/frame behaviour and a full 640x480 instance for real line timing.
module tb_vga_fb_scanout;

    localparam int unsigned LN = 80;     // small instance line total
    localparam int unsigned FR = 4400;   // small instance frame total (80*55)
    localparam logic [63:0] RST_PINS = {17'b0, 4'b1100, 24'b0, 19'b0};

    typedef struct {
        bit          rst;
        logic [2:0]  fator;
        bit          rdy;
        int unsigned fr;
        int unsigned h;
        int unsigned v;
        int unsigned addr;
        logic [7:0]  pix;
        bit          blank;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_s, rst_b;
    logic [2:0]  fator_s;
    logic        rdy_s;
    int unsigned cyc = 0;
    int unsigned t0_s = 0;
    int unsigned vec = 0;
    int unsigned miss = 0;
    vec_t        tbl[$];

    vga_fb_scanout_if bus_s();
    vga_fb_scanout_if bus_b();

    vga_fb_scanout #(
        .LARGURA(16), .ALTURA(12),
        .H_VIS(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_VIS(48), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_s (
        .clk(clk), .reset(rst_s), .fator(fator_s), .fb_ready(rdy_s), .bus(bus_s)
    );

    vga_fb_scanout dut_b (
        .clk(clk), .reset(rst_b), .fator(3'd4), .fb_ready(1'b1), .bus(bus_b)
    );

    always #20 clk = ~clk;

    // Synchronous RAMs holding the low address byte.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus_s.ram_q <= bus_s.ram_rdaddr[7:0];
        bus_b.ram_q <= bus_b.ram_rdaddr[7:0];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] pins_s();
        return {17'b0, bus_s.hsync, bus_s.vsync, bus_s.blank_n, bus_s.frame_start,
                bus_s.vga_r, bus_s.vga_g, bus_s.vga_b, bus_s.ram_rdaddr};
    endfunction

    function automatic logic [63:0] pins_b();
        return {17'b0, bus_b.hsync, bus_b.vsync, bus_b.blank_n, bus_b.frame_start,
                bus_b.vga_r, bus_b.vga_g, bus_b.vga_b, bus_b.ram_rdaddr};
    endfunction

    task automatic add(input bit rst, input logic [2:0] f, input bit r,
                       input int unsigned fr, input int unsigned h, input int unsigned v,
                       input int unsigned addr, input logic [7:0] pix, input bit bl);
        vec_t t;
        t.rst = rst; t.fator = f; t.rdy = r; t.fr = fr; t.h = h; t.v = v;
        t.addr = addr; t.pix = pix; t.blank = bl;
        tbl.push_back(t);
    endtask

    task automatic reset_small(input logic [2:0] f, input logic r);
        @(negedge clk);
        rst_s   = 1'b0;
        fator_s = f;
        rdy_s   = r;
        @(negedge clk);
        chk("reset_pins_small", pins_s(), RST_PINS);
        rst_s = 1'b1;
        t0_s  = cyc;
    endtask

    task automatic wait_to(input int unsigned e);
        if (cyc - t0_s > e) begin
            miss++;
            $display("FAIL sched: at edge %0d, required %0d", cyc - t0_s, e);
        end
        while (cyc - t0_s < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_big();
        int unsigned hs_f1 = 0, hs_r1 = 0, hs_f2 = 0, vs_low = 0;
        logic prev_hs = 1'b1;
        @(negedge clk);
        chk("reset_pins_big", pins_b(), RST_PINS);
        rst_b = 1'b1;
        for (int unsigned e = 1; e <= 1500; e++) begin
            @(posedge clk);
            #1;
            if (prev_hs && !bus_b.hsync) begin
                if (hs_f1 == 0) hs_f1 = e;
                else if (hs_f2 == 0) hs_f2 = e;
            end
            if (!prev_hs && bus_b.hsync && hs_r1 == 0) hs_r1 = e;
            if (!bus_b.vsync) vs_low++;
            prev_hs = bus_b.hsync;
            case (e)
                640: chk("big addr h639 v0", bus_b.ram_rdaddr, 639);
                642: begin
                    chk("big r h639 v0", bus_b.vga_r, 127);
                    chk("big blank h639 v0", bus_b.blank_n, 1);
                end
                643: chk("big blank h640 v0", bus_b.blank_n, 0);
                801: chk("big addr h0 v1", bus_b.ram_rdaddr, 640);
                803: chk("big r h0 v1", bus_b.vga_r, 128);
                default: ;
            endcase
        end
        chk("big hsync first fall", hs_f1, 659);
        chk("big hsync first rise", hs_r1, 755);
        chk("big hsync second fall", hs_f2, 1459);
        chk("big vsync low count", vs_low, 0);
    endtask

    task automatic run_monitor();
        int unsigned hs_f1 = 0, hs_r1 = 0, hs_f2 = 0, vs_f1 = 0, vs_r1 = 0, vs_f2 = 0;
        int unsigned fs_n = 0, fs_f1 = 0, fs_bad = 0, chan_bad = 0, blk0_bad = 0, nz1 = 0;
        logic prev_hs = 1'b1, prev_vs = 1'b1, prev_bl = 1'b0;
        reset_small(3'd2, 1'b0);
        for (int unsigned e = 1; e <= 9000; e++) begin
            @(posedge clk);
            #1;
            if (e == 2000) rdy_s = 1'b1;
            if (prev_hs && !bus_s.hsync) begin
                if (hs_f1 == 0) hs_f1 = e;
                else if (hs_f2 == 0) hs_f2 = e;
            end
            if (!prev_hs && bus_s.hsync && hs_r1 == 0) hs_r1 = e;
            if (prev_vs && !bus_s.vsync) begin
                if (vs_f1 == 0) vs_f1 = e;
                else if (vs_f2 == 0) vs_f2 = e;
            end
            if (!prev_vs && bus_s.vsync && vs_r1 == 0) vs_r1 = e;
            if (bus_s.frame_start) begin
                fs_n++;
                if (fs_f1 == 0) fs_f1 = e;
                if (!(bus_s.blank_n && !prev_bl)) fs_bad++;
            end
            if (bus_s.vga_r != bus_s.vga_g || bus_s.vga_r != bus_s.vga_b) chan_bad++;
            if (bus_s.vga_r != 8'd0) begin
                if (e <= 4402) blk0_bad++;
                else if (e <= 8802) nz1++;
            end
            prev_hs = bus_s.hsync;
            prev_vs = bus_s.vsync;
            prev_bl = bus_s.blank_n;
        end
        chk("hsync first fall", hs_f1, 71);
        chk("hsync first rise", hs_r1, 79);
        chk("hsync second fall", hs_f2, 151);
        chk("vsync first fall", vs_f1, 4003);
        chk("vsync first rise", vs_r1, 4163);
        chk("vsync second fall", vs_f2, 8403);
        chk("frame_start count", fs_n, 3);
        chk("frame_start first", fs_f1, 3);
        chk("frame_start vs blank rise", fs_bad, 0);
        chk("rgb channels equal", chan_bad, 0);
        chk("not-ready frame black", blk0_bad, 0);
        chk("ready frame lit pixels", nz1, 765);
    endtask

    task automatic run_table();
        vec_t t;
        int unsigned e;
        foreach (tbl[i]) begin
            t = tbl[i];
            if (t.rst) reset_small(t.fator, t.rdy);
            else begin
                fator_s = t.fator;
                rdy_s   = t.rdy;
            end
            e = t.fr * FR + t.v * LN + t.h;
            wait_to(e + 1);
            chk($sformatf("addr f%0d fr%0d h%0d v%0d", t.fator, t.fr, t.h, t.v),
                bus_s.ram_rdaddr, t.addr);
            wait_to(e + 3);
            chk($sformatf("rgb f%0d fr%0d h%0d v%0d", t.fator, t.fr, t.h, t.v),
                {bus_s.vga_r, bus_s.vga_g, bus_s.vga_b}, {t.pix, t.pix, t.pix});
            chk($sformatf("blank f%0d fr%0d h%0d v%0d", t.fator, t.fr, t.h, t.v),
                bus_s.blank_n, t.blank);
        end
    endtask

    initial begin
        rst_s   = 1'b0;
        rst_b   = 1'b0;
        fator_s = 3'd4;
        rdy_s   = 1'b1;

        //   rst fator rdy fr  h   v   addr  pix  blank
        add(1, 3'd4, 1, 0,  0,  0,    0,   0, 1);
        add(0, 3'd4, 1, 0, 63,  0,   63,  63, 1);
        add(0, 3'd4, 1, 0, 66,  0,    0,   0, 0);
        add(0, 3'd4, 1, 0,  0,  1,   64,  64, 1);
        add(0, 3'd4, 1, 0, 63, 47, 3071, 255, 1);
        add(0, 3'd4, 1, 0, 10, 48,    0,   0, 0);
        add(1, 3'd2, 1, 0, 15, 12,    0,   0, 1);
        add(0, 3'd2, 1, 0, 17, 12,    1,   1, 1);
        add(0, 3'd2, 1, 0, 47, 12,   31,  31, 1);
        add(0, 3'd2, 1, 0, 49, 12,    0,   0, 1);
        add(0, 3'd2, 1, 0, 16, 13,   32,  32, 1);
        add(0, 3'd2, 1, 0, 47, 35,  767, 255, 1);
        add(0, 3'd2, 1, 0, 16, 36,    0,   0, 1);
        add(1, 3'd0, 1, 0, 22, 18,    0,   0, 1);
        add(0, 3'd0, 1, 0, 26, 18,    2,   2, 1);
        add(0, 3'd0, 1, 0, 39, 29,  191, 191, 1);
        add(0, 3'd0, 1, 0, 41, 29,    0,   0, 1);
        add(0, 3'd0, 1, 0, 39, 30,    0,   0, 1);
        add(1, 3'd5, 1, 0, 26, 18,    2,   2, 1);
        add(0, 3'd5, 1, 0, 39, 29,  191, 191, 1);
        add(1, 3'd1, 1, 0, 30, 20,   38,  38, 1);
        add(0, 3'd3, 1, 0, 39, 29,  191, 191, 1);
        add(0, 3'd3, 1, 0, 24, 40,    0,   0, 1);
        add(0, 3'd3, 1, 1,  7,  6,    0,   0, 1);
        add(0, 3'd3, 1, 1,  9,  6,    1,   1, 1);
        add(0, 3'd3, 1, 1, 24, 18,  592,  80, 1);
        add(0, 3'd3, 1, 1, 24, 40, 1648, 112, 1);
        add(1, 3'd2, 0, 0, 47, 12,   31,   0, 1);
        add(0, 3'd2, 1, 0, 16, 13,   32,   0, 1);
        add(0, 3'd2, 1, 1, 16, 13,   32,  32, 1);
        add(0, 3'd2, 1, 1, 47, 35,  767, 255, 1);

        fork
            run_big();
            begin
                run_table();
                run_monitor();
            end
        join

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
